// File: rtl/rsa_mont_arbiter.sv
// Round-robin arbiter sharing one RSAMont engine between N_REQ requesters.
// One job in flight: accept -> issue to engine -> wait for result -> return to owner.
package rsa_mont_pkg;
    localparam int MOD_WIDTH = 8;

    typedef struct packed {
        logic [MOD_WIDTH-1:0] base;
        logic [MOD_WIDTH-1:0] msg;
        logic [MOD_WIDTH-1:0] key;
        logic [MOD_WIDTH-1:0] modulus;
    } RSAMontModIn;

    typedef struct packed {
        logic [MOD_WIDTH-1:0] result;
    } RSAMontModOut;
endpackage

module rsa_mont_arbiter
    import rsa_mont_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = 32,
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  RSAMontModIn [N_REQ-1:0]       req_in,
    output logic [N_REQ-1:0]              resp_valid,
    input  logic [N_REQ-1:0]              resp_ready,
    output RSAMontModOut                  resp_out,
    output logic                          eng_i_valid,
    input  logic                          eng_i_ready,
    output RSAMontModIn                   eng_i_in,
    input  logic                          eng_o_valid,
    output logic                          eng_o_ready,
    input  RSAMontModOut                  eng_o_out,
    output logic [IW-1:0]                 owner,
    output logic                          busy,
    output logic                          err_spurious,
    output logic [CNT_W-1:0]              busy_cycles
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state;
    logic [IW-1:0]  rr_ptr;
    logic [IW-1:0]  grant_idx;
    logic           grant_found;
    logic           rst_d;

    always_comb begin
        int k;
        logic [IW-1:0] k_idx;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k     = (int'(rr_ptr) + i) % N_REQ;
            k_idx = IW'(k);
            if (!grant_found && req_valid[k_idx]) begin
                grant_found = 1'b1;
                grant_idx   = k_idx;
            end
        end
    end

    // Accept is blocked during reset and for the first cycle after it.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && !rst_d && grant_found)
            req_ready[grant_idx] = 1'b1;
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            eng_i_in     <= '0;
            resp_out     <= '0;
            eng_i_valid  <= 1'b0;
            eng_o_ready  <= 1'b0;
            resp_valid   <= '0;
            err_spurious <= 1'b0;
            busy_cycles  <= '0;
            rst_d        <= 1'b1;
        end else begin
            rst_d <= 1'b0;

            if (busy && (busy_cycles != {CNT_W{1'b1}}))
                busy_cycles <= busy_cycles + 1'b1;

            // A result outside WAIT is flagged and dropped; the FSM ignores it.
            if (eng_o_valid && state != WAIT)
                err_spurious <= 1'b1;

            case (state)
                IDLE: begin
                    if (|req_ready) begin
                        eng_i_in    <= req_in[grant_idx];
                        owner       <= grant_idx;
                        rr_ptr      <= (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        eng_i_valid <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (eng_i_ready) begin
                        eng_i_valid <= 1'b0;
                        eng_o_ready <= 1'b1;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (eng_o_valid) begin
                        resp_out          <= eng_o_out;
                        eng_o_ready       <= 1'b0;
                        resp_valid[owner] <= 1'b1;
                        state             <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready[owner]) begin
                        resp_valid <= '0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_mont_arbiter.sv
// Scoreboard bench for rsa_mont_arbiter with a 10-cycle msg^key mod modulus engine model.
module tb_rsa_mont_arbiter;
    import rsa_mont_pkg::*;

    typedef struct {
        int         idx;
        logic [7:0] res;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [3:0]         req_valid = '0;
    logic [3:0]         req_ready;
    RSAMontModIn [3:0]  req_in = '0;
    logic [3:0]         resp_valid;
    logic [3:0]         resp_rdy = 4'hF;
    RSAMontModOut       resp_out;
    logic               eng_i_valid;
    logic               eng_rdy = 1'b1;
    RSAMontModIn        eng_i_in;
    logic               eng_o_valid;
    logic               eng_o_ready;
    RSAMontModOut       eng_o_out;
    logic [1:0]         owner;
    logic               busy;
    logic               err_spurious;
    logic [31:0]        busy_cycles;

    logic [3:0]         u4_req_ready;
    logic [3:0]         u4_resp_valid;
    RSAMontModOut       u4_resp_out;
    logic               u4_eng_i_valid;
    RSAMontModIn        u4_eng_i_in;
    logic               u4_eng_o_ready;
    logic [1:0]         u4_owner;
    logic               u4_busy;
    logic               u4_err;
    logic [3:0]         u4_busy_cycles;

    logic               spur = 1'b0;
    logic               m_valid = 1'b0;
    logic               m_busy = 1'b0;
    int                 m_cnt = 0;
    logic [7:0]         m_res = '0;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    int   gq[$];

    always #5 clk = ~clk;

    rsa_mont_arbiter #(.N_REQ(4), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_in(req_in),
        .resp_valid(resp_valid), .resp_ready(resp_rdy), .resp_out(resp_out),
        .eng_i_valid(eng_i_valid), .eng_i_ready(eng_rdy), .eng_i_in(eng_i_in),
        .eng_o_valid(eng_o_valid), .eng_o_ready(eng_o_ready), .eng_o_out(eng_o_out),
        .owner(owner), .busy(busy), .err_spurious(err_spurious), .busy_cycles(busy_cycles)
    );

    rsa_mont_arbiter #(.N_REQ(4), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(u4_req_ready), .req_in(req_in),
        .resp_valid(u4_resp_valid), .resp_ready(resp_rdy), .resp_out(u4_resp_out),
        .eng_i_valid(u4_eng_i_valid), .eng_i_ready(eng_rdy), .eng_i_in(u4_eng_i_in),
        .eng_o_valid(eng_o_valid), .eng_o_ready(u4_eng_o_ready), .eng_o_out(eng_o_out),
        .owner(u4_owner), .busy(u4_busy), .err_spurious(u4_err), .busy_cycles(u4_busy_cycles)
    );

    function automatic logic [7:0] modexp(input logic [7:0] m, input logic [7:0] k, input logic [7:0] n);
        logic [15:0] r;
        r = 16'd1;
        for (int i = 0; i < int'(k); i++)
            r = (r * 16'(m)) % 16'(n);
        return r[7:0];
    endfunction

    // Engine model: result appears 10 cycles after the job is taken, held until accepted.
    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_busy  <= 1'b0;
            m_cnt   <= 0;
        end else if (m_valid) begin
            if (eng_o_ready) m_valid <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_valid <= 1'b1;
                m_busy  <= 1'b0;
            end
            m_cnt <= m_cnt - 1;
        end else if (eng_i_valid && eng_rdy) begin
            m_busy <= 1'b1;
            m_cnt  <= 10;
            m_res  <= modexp(eng_i_in.msg, eng_i_in.key, eng_i_in.modulus);
        end
    end

    assign eng_o_valid      = m_valid | spur;
    assign eng_o_out.result = m_res;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    logic [3:0] hs;
    int         hs_idx;
    exp_t       hs_e;

    always @(negedge clk) begin
        if (!rst) begin
            chk("onehot", 64'(($countones(req_ready) <= 1) && ($countones(resp_valid) <= 1)), 64'd1);
            hs = resp_valid & resp_rdy;
            if (hs != 4'd0) begin
                hs_idx = 0;
                for (int i = 0; i < 4; i++)
                    if (hs[2'(i)]) hs_idx = i;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected: got response on requester %0d, expected none", hs_idx);
                end else begin
                    hs_e = sb.pop_front();
                    chk("resp_owner", 64'(hs_idx), 64'(hs_e.idx));
                    chk("resp_data", 64'(resp_out.result), 64'(hs_e.res));
                end
            end
        end
    end

    task automatic set_req(input logic [1:0] i, input logic [7:0] m, input logic [7:0] k, input logic [7:0] n);
        req_in[i]    = '{base: 8'd1, msg: m, key: k, modulus: n};
        req_valid[i] = 1'b1;
    endtask

    task automatic push_exp(input int i, input logic [7:0] r);
        exp_t e;
        e.idx = i;
        e.res = r;
        sb.push_back(e);
    endtask

    // Drops each request after its accept, logging grant order, until none remain.
    task automatic accept_all(input string name);
        logic [3:0] acc;
        int n;
        n = 0;
        gq.delete();
        while (req_valid != 4'd0 && n < 400) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++)
                if (acc[2'(i)]) begin
                    gq.push_back(i);
                    req_valid[2'(i)] = 1'b0;
                end
            n++;
        end
        if (req_valid != 4'd0) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: got pending %b, expected 0000", name, req_valid);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((sb.size() != 0 || busy) && n < 400);
        if (sb.size() != 0 || busy) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: got %0d pending, expected 0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        RSAMontModIn held;

        // Reset state
        req_valid = 4'hF;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_eng_i_valid", 64'(eng_i_valid), 64'd0);
        chk("rst_eng_o_ready", 64'(eng_o_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_err", 64'(err_spurious), 64'd0);
        chk("rst_busy_cycles", 64'(busy_cycles), 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_after_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        req_valid = 4'h0;
        @(posedge clk);
        #1;

        // 1. Single job from requester 1: 5^3 mod 33 = 26
        set_req(2'd1, 8'd5, 8'd3, 8'd33);
        push_exp(1, 8'd26);
        @(negedge clk);
        chk("t1_req_ready", 64'(req_ready), 64'b0010);
        chk("t1_ivalid_accept_cycle", 64'(eng_i_valid), 64'd0);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("t1_ivalid_next_cycle", 64'(eng_i_valid), 64'd1);
        chk("t1_owner", 64'(owner), 64'd1);
        chk("t1_eng_msg", 64'(eng_i_in.msg), 64'd5);
        @(posedge clk);
        #1;
        wait_done("t1");

        // 2. Fairness from reset: all four valid together
        do_reset();
        set_req(2'd0, 8'd2, 8'd5, 8'd13);
        set_req(2'd1, 8'd3, 8'd4, 8'd7);
        set_req(2'd2, 8'd7, 8'd2, 8'd10);
        set_req(2'd3, 8'd6, 8'd2, 8'd11);
        push_exp(0, 8'd6);
        push_exp(1, 8'd4);
        push_exp(2, 8'd9);
        push_exp(3, 8'd3);
        accept_all("t2");
        chk("t2_ngrants", 64'(gq.size()), 64'd4);
        if (gq.size() == 4)
            for (int i = 0; i < 4; i++) chk("t2_grant_order", 64'(gq[i]), 64'(i));
        wait_done("t2");

        set_req(2'd0, 8'd9, 8'd2, 8'd17);
        set_req(2'd3, 8'd2, 8'd7, 8'd100);
        push_exp(0, 8'd13);
        push_exp(3, 8'd28);
        accept_all("t2b");
        chk("t2b_ngrants", 64'(gq.size()), 64'd2);
        if (gq.size() == 2) begin
            chk("t2b_first", 64'(gq[0]), 64'd0);
            chk("t2b_second", 64'(gq[1]), 64'd3);
        end
        wait_done("t2b");

        // 3. Backpressure on engine input and on response
        eng_rdy = 1'b0;
        resp_rdy[2] = 1'b0;
        set_req(2'd2, 8'd3, 8'd5, 8'd50);
        push_exp(2, 8'd43);
        push_exp(0, 8'd4);
        held = '{base: 8'd1, msg: 8'd3, key: 8'd5, modulus: 8'd50};
        @(negedge clk);
        chk("t3_req_ready", 64'(req_ready), 64'b0100);
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        set_req(2'd0, 8'd5, 8'd2, 8'd7);
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            chk("t3_ivalid_held", 64'(eng_i_valid), 64'd1);
            chk("t3_iin_stable", 64'(eng_i_in), 64'(held));
            chk("t3_no_grant_issue", 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        eng_rdy = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!resp_valid[2] && n < 100);
        chk("t3_resp_seen", 64'(resp_valid[2]), 64'd1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk);
            chk("t3_resp_valid_held", 64'(resp_valid), 64'b0100);
            chk("t3_resp_out_stable", 64'(resp_out.result), 64'd43);
            chk("t3_no_grant_resp", 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        resp_rdy[2] = 1'b1;
        accept_all("t3");
        wait_done("t3");

        // 4. Spurious engine result while idle
        spur = 1'b1;
        @(posedge clk);
        #1;
        spur = 1'b0;
        @(negedge clk);
        chk("t4_err_set", 64'(err_spurious), 64'd1);
        chk("t4_still_idle", 64'(busy), 64'd0);
        @(posedge clk);
        #1;
        set_req(2'd1, 8'd4, 8'd3, 8'd50);
        push_exp(1, 8'd14);
        accept_all("t4");
        wait_done("t4");
        chk("t4_err_sticky", 64'(err_spurious), 64'd1);

        // 5. Reset during WAIT drops the job
        set_req(2'd3, 8'd7, 8'd3, 8'd20);
        accept_all("t5a");
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!eng_o_ready && n < 50);
        chk("t5_in_wait", 64'(eng_o_ready), 64'd1);
        @(posedge clk);
        #1;
        set_req(2'd1, 8'd5, 8'd2, 8'd7);
        set_req(2'd3, 8'd9, 8'd2, 8'd17);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("t5_req_ready", 64'(req_ready), 64'd0);
        chk("t5_eng_i_valid", 64'(eng_i_valid), 64'd0);
        chk("t5_eng_o_ready", 64'(eng_o_ready), 64'd0);
        chk("t5_resp_valid", 64'(resp_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_err_cleared", 64'(err_spurious), 64'd0);
        chk("t5_busy_cycles", 64'(busy_cycles), 64'd0);
        chk("t5_busy_cycles4", 64'(u4_busy_cycles), 64'd0);
        @(posedge clk);
        #1;
        push_exp(1, 8'd4);
        push_exp(3, 8'd13);
        accept_all("t5");
        chk("t5_ngrants", 64'(gq.size()), 64'd2);
        if (gq.size() == 2) begin
            chk("t5_first", 64'(gq[0]), 64'd1);
            chk("t5_second", 64'(gq[1]), 64'd3);
        end
        wait_done("t5");

        // 6. Narrow counter saturates, wide counter keeps counting
        chk("t6_sat", 64'(u4_busy_cycles), 64'd15);
        chk("t6_wide_counts", 64'(busy_cycles >= 32'd20), 64'd1);
        set_req(2'd0, 8'd7, 8'd2, 8'd10);
        push_exp(0, 8'd9);
        accept_all("t6");
        wait_done("t6");
        chk("t6_sat_hold", 64'(u4_busy_cycles), 64'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
